sfr_bank_gen: RTL

Parametrised successor of the team's fixed 4-register SFR block, with the same byte lanes and register map at offsets 0x0..0xC. Adds a configurable register count and data width, byte-strobe writes, a hardware-set/W1C interrupt status with mask and IRQ output, a sticky lock bit, and an error response for unmapped accesses. Sits between the bus-side register agent (UVM RAL frontdoor) and the block's datapath.

---
 rtl/sfr_bank_pkg.sv | 30 +++
 rtl/sfr_resp_pipe.sv | 36 +++
 rtl/sfr_bank_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/sfr_bank_pkg.sv
// Shared register-map constants and helpers for the parametrised SFR bank.
package sfr_bank_pkg;

  localparam int unsigned IDX_CONTROL = 0;
  localparam int unsigned IDX_STS     = 1;
  localparam int unsigned IDX_MSK     = 2;
  localparam int unsigned IDX_DEBUG   = 3;

  // Widest supported bus; narrower instances slice the low bits.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_BYTES  = MAX_DATA_W / 8;

  typedef enum logic [1:0] {ACC_RW, ACC_W1C, ACC_RO} acc_e;

  // Access behaviour of a word index; anything past the bank is unmapped.
  function automatic acc_e acc_type(input int unsigned idx, input int unsigned num_regs);
    if (idx >= num_regs) return ACC_RO;
    if (idx == IDX_STS)  return ACC_W1C;
    return ACC_RW;
  endfunction

  // Expand byte strobes into a per-bit write mask.
  function automatic logic [MAX_DATA_W-1:0] strb_to_mask(input logic [MAX_BYTES-1:0] strb);
    logic [MAX_DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_BYTES; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

endpackage

// File: rtl/sfr_resp_pipe.sv
// One-cycle registered response stage: write/read pulses, error flags, read data.
module sfr_resp_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_acc,
  input  logic              i_werr,
  input  logic              i_rd_acc,
  input  logic              i_rerr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_wready,
  output logic              o_werr,
  output logic              o_rvalid,
  output logic              o_rerr,
  output logic [DATA_W-1:0] o_rdata
);

  // Pulses last one cycle; read data is only replaced by a new read.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_wready <= 1'b0;
      o_werr   <= 1'b0;
      o_rvalid <= 1'b0;
      o_rerr   <= 1'b0;
      o_rdata  <= '0;
    end else begin
      o_wready <= i_wr_acc;
      o_werr   <= i_wr_acc & i_werr;
      o_rvalid <= i_rd_acc;
      o_rerr   <= i_rd_acc & i_rerr;
      if (i_rd_acc) o_rdata <= i_rdata;
    end
  end

endmodule

// File: rtl/sfr_bank_gen.sv
// Parametrised SFR bank: RW control/mask/debug/GP words, W1C interrupt status
// with hardware set, sticky lock on CONTROL/INTR_MSK, error on unmapped access.
module sfr_bank_gen
  import sfr_bank_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 8,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] CTRL_RST = 5,
  parameter logic [DATA_W-1:0] MSK_RST  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrobe,
  input  logic                i_rd_en,
  input  logic [ADDR_W-1:0]   i_raddr,
  input  logic [DATA_W-1:0]   i_hw_evt,
  output logic                o_wready,
  output logic                o_rvalid,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_werr,
  output logic                o_rerr,
  output logic                o_irq,
  output logic [DATA_W-1:0]   o_ctrl
);

  localparam int BYTES = DATA_W / 8;
  localparam int IW    = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [ADDR_W-1:0]     widx_full, ridx_full;
  logic [IW-1:0]         wi, ri;
  logic                  waddr_err, raddr_err, locked, w_locked, wr_ok;
  acc_e                  wacc;
  logic [MAX_DATA_W-1:0] wmask64;
  logic [DATA_W-1:0]     wmask, w1c, sts_next, rd_data;
  logic                  irq_q;

  // Word index from byte address; misaligned or past-the-end addresses are errors.
  assign widx_full = i_waddr / ADDR_W'(BYTES);
  assign ridx_full = i_raddr / ADDR_W'(BYTES);
  assign waddr_err = ((i_waddr % ADDR_W'(BYTES)) != '0) || (widx_full >= ADDR_W'(NUM_REGS));
  assign raddr_err = ((i_raddr % ADDR_W'(BYTES)) != '0) || (ridx_full >= ADDR_W'(NUM_REGS));
  assign wi        = widx_full[IW-1:0];
  assign ri        = ridx_full[IW-1:0];

  // LOCK is the top bit of CONTROL; once set it freezes CONTROL and INTR_MSK.
  assign locked   = regs[IDX_CONTROL][DATA_W-1];
  assign w_locked = locked && (wi == IW'(IDX_CONTROL) || wi == IW'(IDX_MSK));
  assign wr_ok    = i_wr_en && !waddr_err && !w_locked;
  assign wacc     = acc_type(32'(wi), NUM_REGS);

  assign wmask64  = strb_to_mask(MAX_BYTES'(i_wstrobe));
  assign wmask    = wmask64[DATA_W-1:0];

  // Hardware set wins over a same-cycle software clear.
  assign w1c      = (wr_ok && wacc == ACC_W1C) ? (i_wdata & wmask) : '0;
  assign sts_next = (regs[IDX_STS] & ~w1c) | i_hw_evt;

  // Reads see the pre-write contents; errored reads return zero.
  assign rd_data  = raddr_err ? '0 : regs[ri];

  // Register bank update: status every cycle, RW words on a clean strobed write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      regs[IDX_CONTROL] <= CTRL_RST;
      regs[IDX_MSK]     <= MSK_RST;
    end else begin
      regs[IDX_STS] <= sts_next;
      if (wr_ok && wacc == ACC_RW) regs[wi] <= (regs[wi] & ~wmask) | (i_wdata & wmask);
    end
  end

  // Level interrupt, registered from the current status and mask.
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= |(regs[IDX_STS] & regs[IDX_MSK]);
  end

  assign o_irq  = irq_q;
  assign o_ctrl = regs[IDX_CONTROL];

  sfr_resp_pipe #(.DATA_W(DATA_W)) u_resp (
    .clk      (clk),
    .reset    (reset),
    .i_wr_acc (i_wr_en),
    .i_werr   (!wr_ok),
    .i_rd_acc (i_rd_en),
    .i_rerr   (raddr_err),
    .i_rdata  (rd_data),
    .o_wready (o_wready),
    .o_werr   (o_werr),
    .o_rvalid (o_rvalid),
    .o_rerr   (o_rerr),
    .o_rdata  (o_rdata)
  );

endmodule
